// File: rtl/multicycle_control.sv
// Multicycle controller: fetch/decode/execute FSM emitting datapath controls.
// Ports: clk, reset (async low), instruction/instrValid/zero/memReady in; control strobes and trap out.
module multicycle_control #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        instrValid,
  input  logic        zero,
  input  logic        memReady,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        regWrite,
  output logic        regDst,
  output logic        memRead,
  output logic        memWrite,
  output logic        memToReg,
  output logic        aluSrc,
  output logic [3:0]  aluControl,
  output logic        jump,
  output logic        branchMuxSelect,
  output logic        jalSelect,
  output logic        jalSelect2,
  output logic        jrSelect,
  output logic        trap
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_JAL  = 5'b00010;
  localparam logic [4:0] OP_BEQ  = 5'b00011;
  localparam logic [4:0] OP_BNE  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEMWAIT,
    WB,
    BRANCH,
    JUMP,
    TRAP
  } state_t;

  state_t         state;
  logic [4:0]     opR;
  logic [5:0]     fnR;
  logic [CW-1:0]  cnt;

  // Only opcode and funct matter to the controller.
  logic unusedBits;
  assign unusedBits = ^instruction[26:6];

  logic isR, fnAdd, fnSub, fnAnd, fnOr, fnSlt;
  logic isAluR, isJr, isJ, isJal, isBeq, isBne;
  logic isAddi, isLw, isSw, legal;
  logic toExec, toBranch;

  assign isR    = (opR == OP_R);
  assign fnAdd  = isR && (fnR == FN_ADD);
  assign fnSub  = isR && (fnR == FN_SUB);
  assign fnAnd  = isR && (fnR == FN_AND);
  assign fnOr   = isR && (fnR == FN_OR);
  assign fnSlt  = isR && (fnR == FN_SLT);
  assign isAluR = fnAdd | fnSub | fnAnd | fnOr | fnSlt;
  assign isJr   = isR && (fnR == FN_JR);
  assign isJ    = (opR == OP_J);
  assign isJal  = (opR == OP_JAL);
  assign isBeq  = (opR == OP_BEQ);
  assign isBne  = (opR == OP_BNE);
  assign isAddi = (opR == OP_ADDI);
  assign isLw   = (opR == OP_LW);
  assign isSw   = (opR == OP_SW);

  assign toExec   = isAluR | isAddi | isLw | isSw;
  assign toBranch = isBeq | isBne;
  assign legal    = toExec | toBranch | isJ | isJal | isJr;

  logic [3:0] rAluCtl;
  always_comb begin
    rAluCtl = ALU_ADD;
    unique case (1'b1)
      fnAdd:   rAluCtl = ALU_ADD;
      fnSub:   rAluCtl = ALU_SUB;
      fnAnd:   rAluCtl = ALU_AND;
      fnOr:    rAluCtl = ALU_OR;
      fnSlt:   rAluCtl = ALU_SLT;
      default: rAluCtl = ALU_ADD;
    endcase
  end

  logic [3:0] execAlu;
  assign execAlu = isAluR ? rAluCtl : ALU_ADD;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      opR   <= '0;
      fnR   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (instrValid) begin
            opR   <= instruction[31:27];
            fnR   <= instruction[5:0];
            state <= DECODE;
          end
        end
        DECODE: begin
          if (!legal)        state <= TRAP;
          else if (toExec)   state <= EXEC;
          else if (toBranch) state <= BRANCH;
          else               state <= JUMP;
        end
        EXEC: begin
          cnt   <= '0;
          state <= (isLw | isSw) ? MEMWAIT : WB;
        end
        MEMWAIT: begin
          // A ready in the final allowed cycle still completes.
          if (memReady)         state <= isLw ? WB : FETCH;
          else if (cnt == LAST) state <= TRAP;
          else                  cnt   <= cnt + 1'b1;
        end
        WB:     state <= FETCH;
        BRANCH: state <= FETCH;
        JUMP:   state <= FETCH;
        TRAP:   state <= TRAP;
      endcase
    end
  end

  always_comb begin
    irWrite         = 1'b0;
    pcWrite         = 1'b0;
    regWrite        = 1'b0;
    regDst          = 1'b0;
    memRead         = 1'b0;
    memWrite        = 1'b0;
    memToReg        = 1'b0;
    aluSrc          = 1'b0;
    aluControl      = 4'b0000;
    jump            = 1'b0;
    branchMuxSelect = 1'b0;
    jalSelect       = 1'b0;
    jalSelect2      = 1'b0;
    jrSelect        = 1'b0;
    trap            = 1'b0;
    case (state)
      FETCH: begin
        // Gated by reset so nothing strobes while reset is held.
        irWrite = instrValid & reset;
      end
      DECODE: begin
      end
      EXEC: begin
        aluControl = execAlu;
        aluSrc     = isAddi | isLw | isSw;
      end
      MEMWAIT: begin
        memRead  = isLw;
        memWrite = isSw;
        pcWrite  = isSw & memReady;
      end
      WB: begin
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        regDst   = isAluR;
        memToReg = isLw;
        // The ALU result is still the write-back source here.
        if (!isLw) begin
          aluControl = execAlu;
          aluSrc     = isAddi;
        end
      end
      BRANCH: begin
        aluControl      = ALU_SUB;
        pcWrite         = 1'b1;
        branchMuxSelect = (isBeq & zero) | (isBne & ~zero);
      end
      JUMP: begin
        pcWrite    = 1'b1;
        jump       = isJ | isJal;
        jalSelect  = isJal;
        jalSelect2 = isJal;
        regWrite   = isJal;
        jrSelect   = isJr;
      end
      TRAP: begin
        trap = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed literal cases plus randomized
// instruction streams checked cycle by cycle against a per-instruction schedule.
module tb_multicycle_control;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        instrValid, zero, memReady;
  logic        irWrite, pcWrite, regWrite, regDst, memRead, memWrite;
  logic        memToReg, aluSrc, jump, branchMuxSelect;
  logic        jalSelect, jalSelect2, jrSelect, trap;
  logic [3:0]  aluControl;

  multicycle_control #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .instrValid(instrValid), .zero(zero), .memReady(memReady),
    .irWrite(irWrite), .pcWrite(pcWrite), .regWrite(regWrite),
    .regDst(regDst), .memRead(memRead), .memWrite(memWrite),
    .memToReg(memToReg), .aluSrc(aluSrc), .aluControl(aluControl),
    .jump(jump), .branchMuxSelect(branchMuxSelect),
    .jalSelect(jalSelect), .jalSelect2(jalSelect2),
    .jrSelect(jrSelect), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       irWrite, pcWrite, regWrite, regDst;
    logic       memRead, memWrite, memToReg, aluSrc;
    logic [3:0] aluControl;
    logic       jump, branchMuxSelect, jalSelect, jalSelect2, jrSelect, trap;
  } outs_t;

  typedef enum int {
    K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_JR, K_J, K_JAL,
    K_BEQ, K_BNE, K_ADDI, K_LW, K_SW, K_BADOP, K_BADFN
  } kind_t;

  outs_t act, expV;
  assign act = {irWrite, pcWrite, regWrite, regDst, memRead, memWrite,
                memToReg, aluSrc, aluControl, jump, branchMuxSelect,
                jalSelect, jalSelect2, jrSelect, trap};

  int    total = 0;
  int    passed = 0;
  bit    chk = 1'b0;
  string tag = "";

  always @(negedge clk) begin
    #2;
    if (chk) begin
      total++;
      if (act === expV) passed++;
      else $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, act, expV);
    end
  end

  task automatic checkNow(input string t, input logic [31:0] a,
                          input logic [31:0] b);
    total++;
    if (a === b) passed++;
    else $display("FAIL %s t=%0t got=%h exp=%h", t, $time, a, b);
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] enc(input kind_t k);
    logic [31:0] w;
    logic [5:0]  f;
    w = $urandom;
    w[31:27] = 5'd0;
    case (k)
      K_ADD:  w[5:0] = 6'b100000;
      K_SUB:  w[5:0] = 6'b100010;
      K_AND:  w[5:0] = 6'b100100;
      K_OR:   w[5:0] = 6'b100101;
      K_SLT:  w[5:0] = 6'b101010;
      K_JR:   w[5:0] = 6'b001000;
      K_J:    w[31:27] = 5'd1;
      K_JAL:  w[31:27] = 5'd2;
      K_BEQ:  w[31:27] = 5'd3;
      K_BNE:  w[31:27] = 5'd4;
      K_ADDI: w[31:27] = 5'd5;
      K_LW:   w[31:27] = 5'd6;
      K_SW:   w[31:27] = 5'd7;
      K_BADOP: w[31:27] = 5'($urandom_range(8, 31));
      K_BADFN: begin
        do f = 6'($urandom_range(0, 63));
        while (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
               f == 6'b100101 || f == 6'b101010 || f == 6'b001000);
        w[5:0] = f;
      end
      default: ;
    endcase
    return w;
  endfunction

  function automatic logic [3:0] aluOf(input kind_t k);
    case (k)
      K_SUB:   return 4'b0110;
      K_AND:   return 4'b0000;
      K_OR:    return 4'b0001;
      K_SLT:   return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  task automatic cyc(input logic iv, input logic [31:0] ins, input logic z,
                     input logic mr, input outs_t e, input string t);
    @(negedge clk);
    instrValid  = iv;
    instruction = ins;
    zero        = z;
    memReady    = mr;
    expV        = e;
    tag         = t;
    chk         = 1'b1;
  endtask

  task automatic doReset();
    @(negedge clk);
    instrValid  = 1'b0;
    instruction = $urandom;
    zero        = rb();
    memReady    = rb();
    expV        = '0;
    tag         = "reset";
    chk         = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk);
    reset      = 1'b1;
    instrValid = 1'b0;
    expV       = '0;
    tag        = "postReset";
  endtask

  // Expected outputs come from the per-instruction cycle schedule.
  task automatic runInstr(input kind_t k, input int w, input bit z,
                          input int idle);
    outs_t e;
    bit    imm, trapped, last, mem;
    imm  = (k == K_ADDI || k == K_LW || k == K_SW);
    mem  = (k == K_LW || k == K_SW);
    trapped = 1'b0;
    repeat (idle) cyc(1'b0, $urandom, rb(), rb(), '0, "idle");
    e = '0; e.irWrite = 1'b1;
    cyc(1'b1, enc(k), rb(), rb(), e, "fetch");
    cyc(rb(), $urandom, rb(), rb(), '0, "decode");
    case (k)
      K_BADOP, K_BADFN: trapped = 1'b1;
      K_J, K_JAL, K_JR: begin
        e = '0;
        e.pcWrite    = 1'b1;
        e.jump       = (k != K_JR);
        e.jalSelect  = (k == K_JAL);
        e.jalSelect2 = (k == K_JAL);
        e.regWrite   = (k == K_JAL);
        e.jrSelect   = (k == K_JR);
        cyc(rb(), $urandom, rb(), rb(), e, "jump");
      end
      K_BEQ, K_BNE: begin
        e = '0;
        e.pcWrite    = 1'b1;
        e.aluControl = 4'b0110;
        e.branchMuxSelect = (k == K_BEQ) ? z : !z;
        cyc(rb(), $urandom, z, rb(), e, "branch");
      end
      default: begin
        e = '0; e.aluControl = aluOf(k); e.aluSrc = imm;
        cyc(rb(), $urandom, rb(), rb(), e, "exec");
        if (mem) begin
          for (int i = 0; i < w && i < TO; i++) begin
            last = (i == w - 1);
            e = '0;
            e.memRead  = (k == K_LW);
            e.memWrite = (k == K_SW);
            e.pcWrite  = last && (k == K_SW);
            cyc(rb(), $urandom, rb(), last, e, "memwait");
          end
          if (w > TO) trapped = 1'b1;
          else if (k == K_LW) begin
            e = '0; e.regWrite = 1'b1; e.pcWrite = 1'b1; e.memToReg = 1'b1;
            cyc(rb(), $urandom, rb(), rb(), e, "wbLoad");
          end
        end else begin
          e = '0;
          e.regWrite   = 1'b1;
          e.pcWrite    = 1'b1;
          e.regDst     = (k != K_ADDI);
          e.aluControl = aluOf(k);
          e.aluSrc     = imm;
          cyc(rb(), $urandom, rb(), rb(), e, "wbAlu");
        end
      end
    endcase
    if (trapped) begin
      e = '0; e.trap = 1'b1;
      repeat (3) cyc(rb(), $urandom, rb(), rb(), e, "trap");
      doReset();
    end
  endtask

  initial begin
    kind_t k;
    int    r;
    reset       = 1'b0;
    instrValid  = 1'b0;
    instruction = '0;
    zero        = 1'b0;
    memReady    = 1'b0;
    repeat (2) @(negedge clk);

    // Reset held: outputs stay low even with a valid instruction.
    cyc(1'b1, enc(K_ADD), 1'b0, 1'b1, '0, "inReset");
    cyc(1'b1, enc(K_ADD), 1'b0, 1'b1, '0, "inReset2");
    @(negedge clk);
    reset = 1'b1;
    instrValid = 1'b0;
    expV = '0;
    tag = "released";

    // ADD, hand-computed schedule.
    cyc(1'b1, enc(K_ADD), 1'b0, 1'b0,
        outs_t'{irWrite: 1'b1, default: '0}, "addC0");
    cyc(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, "addC1");
    cyc(1'b0, $urandom, 1'b0, 1'b0,
        outs_t'{aluControl: 4'b0010, default: '0}, "addC2");
    cyc(1'b0, $urandom, 1'b0, 1'b0,
        outs_t'{regWrite: 1'b1, regDst: 1'b1, aluControl: 4'b0010,
                pcWrite: 1'b1, default: '0}, "addC3");

    // BNE both ways.
    cyc(1'b1, enc(K_BNE), 1'b1, 1'b0,
        outs_t'{irWrite: 1'b1, default: '0}, "bneF");
    cyc(1'b0, $urandom, 1'b1, 1'b0, '0, "bneD");
    cyc(1'b0, $urandom, 1'b0, 1'b0,
        outs_t'{pcWrite: 1'b1, aluControl: 4'b0110,
                branchMuxSelect: 1'b1, default: '0}, "bneTaken");
    cyc(1'b1, enc(K_BNE), 1'b0, 1'b0,
        outs_t'{irWrite: 1'b1, default: '0}, "bneF2");
    cyc(1'b0, $urandom, 1'b0, 1'b0, '0, "bneD2");
    cyc(1'b0, $urandom, 1'b1, 1'b0,
        outs_t'{pcWrite: 1'b1, aluControl: 4'b0110, default: '0},
        "bneNotTaken");

    // JAL: one jump cycle, then back in FETCH.
    cyc(1'b1, enc(K_JAL), 1'b0, 1'b0,
        outs_t'{irWrite: 1'b1, default: '0}, "jalF");
    cyc(1'b0, $urandom, 1'b0, 1'b0, '0, "jalD");
    cyc(1'b0, $urandom, 1'b0, 1'b0,
        outs_t'{jump: 1'b1, jalSelect: 1'b1, jalSelect2: 1'b1,
                regWrite: 1'b1, pcWrite: 1'b1, default: '0}, "jalJ");
    cyc(1'b0, $urandom, 1'b0, 1'b0, '0, "jalDone");

    // LW: three not-ready cycles, ready on the fourth.
    runInstr(K_LW, 4, 1'b0, 0);
    // Illegal opcode 11111.
    cyc(1'b1, {5'b11111, 27'h0}, 1'b0, 1'b0,
        outs_t'{irWrite: 1'b1, default: '0}, "badF");
    cyc(1'b0, $urandom, 1'b0, 1'b0, '0, "badD");
    cyc(1'b1, $urandom, 1'b0, 1'b1,
        outs_t'{trap: 1'b1, default: '0}, "badTrap");
    doReset();
    // SW memory timeout.
    runInstr(K_SW, TO + 1, 1'b0, 1);

    // Reset in the middle of MEMWAIT.
    runInstr(K_ADD, 0, 1'b0, 0);
    cyc(1'b1, enc(K_SW), 1'b0, 1'b0,
        outs_t'{irWrite: 1'b1, default: '0}, "swF");
    cyc(1'b0, $urandom, 1'b0, 1'b0, '0, "swD");
    cyc(1'b0, $urandom, 1'b0, 1'b0,
        outs_t'{aluControl: 4'b0010, aluSrc: 1'b1, default: '0}, "swE");
    cyc(1'b0, $urandom, 1'b0, 1'b0,
        outs_t'{memWrite: 1'b1, default: '0}, "swWait");
    #3 reset = 1'b0;
    #1 checkNow("memWriteDrop", {31'd0, memWrite}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    instrValid = 1'b0;
    memReady = 1'b0;
    expV = '0;
    tag = "afterMidReset";
    runInstr(K_ADDI, 0, 1'b0, 0);

    // Randomized stream.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4)      k = K_BADOP;
      else if (r < 8) k = K_BADFN;
      else            k = kind_t'($urandom_range(0, 12));
      runInstr(k, $urandom_range(1, TO + 1), rb(), $urandom_range(0, 2));
    end

    @(negedge clk);
    chk = 1'b0;
    #3;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum number of cycles spent waiting on memReady before a trap.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates occur on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low.
REQ-004 SHALL have port instruction, input, 32 bits: opcode is [31:27], funct is [5:0].
REQ-005 SHALL have port instrValid, input, 1 bit: instruction is valid during FETCH.
REQ-006 SHALL have port zero, input, 1 bit: ALU zero flag, sampled in BRANCH.
REQ-007 SHALL have port memReady, input, 1 bit: data memory has completed the access.
REQ-008 SHALL have port irWrite, output, 1 bit: latch the instruction.
REQ-009 SHALL have port pcWrite, output, 1 bit: commit the next PC.
REQ-010 SHALL have port regWrite, output, 1 bit: register file write enable.
REQ-011 SHALL have port regDst, output, 1 bit: 1 selects the rd field.
REQ-012 SHALL have ports memRead and memWrite, output, 1 bit each: data memory request.
REQ-013 SHALL have port memToReg, output, 1 bit: write-back comes from memory.
REQ-014 SHALL have port aluSrc, output, 1 bit: 1 selects the immediate.
REQ-015 SHALL have port aluControl, output, 4 bits: ADD=0010, SUB=0110, AND=0000, OR=0001, SLT=0111.
REQ-016 SHALL have ports jump, branchMuxSelect, jalSelect, jalSelect2 and jrSelect, output, 1 bit each: next-PC and link-path selects.
REQ-017 SHALL have port trap, output, 1 bit: sticky error flag (illegal instruction or memory timeout).

Function
REQ-018 SHALL implement states FETCH, DECODE, EXEC, MEMWAIT, WB, BRANCH, JUMP and TRAP, held in one registered state variable.
REQ-019 SHALL stay in FETCH while instrValid=0; when instrValid=1 it SHALL pulse irWrite for one cycle and go to DECODE.
REQ-020 SHALL latch opcode and funct in the FETCH handshake cycle; later changes on instruction SHALL have no effect until the next FETCH.
REQ-021 SHALL decode opcodes as: 00000 R-type, 00001 J, 00010 JAL, 00011 BEQ, 00100 BNE, 00101 ADDI, 00110 LW, 00111 SW.
REQ-022 SHALL decode R-type funct as: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 001000 JR.
REQ-023 SHALL treat any other opcode, or any other R-type funct, as illegal: DECODE goes to TRAP.
REQ-024 SHALL transition from DECODE as follows:
- R-ALU, ADDI, LW, SW go to EXEC.
- BEQ, BNE go to BRANCH.
- J, JAL, JR go to JUMP.
REQ-025 SHALL drive aluControl in EXEC from funct for R-ALU and as ADD for ADDI, LW and SW; aluSrc SHALL be 1 for ADDI, LW and SW.
REQ-026 SHALL transition from EXEC as follows: R-ALU and ADDI go to WB; LW and SW go to MEMWAIT.
REQ-027 SHALL, in MEMWAIT, hold memRead=1 (LW) or memWrite=1 (SW) until the cycle in which memReady=1.
REQ-028 SHALL, when memReady=1 in MEMWAIT: for LW go to WB; for SW pulse pcWrite and go to FETCH.
REQ-029 SHALL count cycles spent in MEMWAIT, clearing the counter on entry; when the count reaches TIMEOUT with memReady=0, it SHALL go to TRAP and drop memRead and memWrite.
REQ-030 SHALL, in WB, assert regWrite=1 and pcWrite=1 for one cycle, then go to FETCH:
- regDst=1 for R-ALU.
- memToReg=1 for LW.
REQ-031 SHALL, in BRANCH, drive aluControl=SUB and pcWrite=1, then go to FETCH.
- branchMuxSelect = (BEQ and zero) or (BNE and not zero).
REQ-032 SHALL, in JUMP, assert pcWrite=1 for one cycle, then go to FETCH:
- J: jump=1.
- JAL: jump=1, jalSelect=1, jalSelect2=1, regWrite=1.
- JR: jrSelect=1.
REQ-033 SHALL hold TRAP with trap=1 until reset, with all other outputs 0.
REQ-034 SHALL drive every output not named for the current state to 0; all outputs SHALL be glitch-free registered or state-decoded.
REQ-035 SHALL give instruction latencies in cycles, excluding FETCH wait: R/ADDI 4, LW 4+w, SW 3+w, BEQ/BNE/J/JAL/JR 3, where w is the number of MEMWAIT cycles.

Reset
REQ-036 SHALL, on reset=0, immediately force FETCH, clear the latched fields, the timeout counter and trap, and drive all outputs to 0, including during MEMWAIT.
REQ-037 SHALL make its first irWrite possible on the first rising edge after reset deasserts.

Verification
REQ-038 SHALL pass: ADD (opcode 0, funct 100000), instrValid=1 -> irWrite at cycle 0; WB at cycle 3 with regWrite=1, regDst=1, aluControl=0010, pcWrite=1.
REQ-039 SHALL pass: LW with memReady held 0 for 3 cycles -> memRead=1 for 4 cycles, then WB with memToReg=1, regWrite=1.
REQ-040 SHALL pass: BNE with zero=0 -> branchMuxSelect=1, pcWrite=1; the same with zero=1 -> branchMuxSelect=0, pcWrite=1.
REQ-041 SHALL pass: JAL -> a single JUMP cycle with jump=1, jalSelect=1, jalSelect2=1, regWrite=1, pcWrite=1.
REQ-042 SHALL pass: opcode 11111 -> trap=1 after DECODE; SW with memReady=0 and TIMEOUT=4 -> trap=1 after 4 MEMWAIT cycles.
REQ-043 SHALL pass: reset pulled low mid-MEMWAIT -> memWrite drops immediately; the controller resumes in FETCH.
